io_channels: RTL and testbench

Parametrised multi-unit block-transfer I/O controller for the MIX core. It serves IN/OUT requests for up to UNITS devices concurrently. Each unit moves one BLOCK-word record between MIX memory and its device word stream. All units share the single memory port behind the CPU: the CPU has priority, and the units arbitrate round-robin among themselves. The controller exposes per-unit busy flags for JBUS/JRED and per-unit completion pulses.

---
 rtl/mix_io_pkg.sv | 25 ++
 rtl/io_channels_if.sv | 49 ++++
 rtl/io_unit.sv | 116 +++++++++++
 rtl/io_channels.sv | 117 +++++++++++
 tb/tb_io_channels.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mix_io_pkg.sv
// Shared types and constants for the MIX block-transfer I/O controller.
// Holds the per-unit state encoding, direction codes and default widths.
package mix_io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAITRD,
        ST_SEND,
        ST_RECV,
        ST_STORE
    } unit_state_e;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    localparam int DEF_MAG_W  = 30;
    localparam int DEF_ADDR_W = 12;

    // Unit-select width; a single unit still gets a 1-bit selector.
    function automatic int unit_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_channels_if.sv
// Start, memory-port and device-stream bundle of the I/O controller.
// master = CPU/decoder/memory/device side, slave = the controller.
interface io_channels_if
    import mix_io_pkg::*;
#(
    parameter int UNITS  = 4,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int MAG_W  = DEF_MAG_W
);
    localparam int UW = unit_w(UNITS);

    logic                   start;
    logic [UW-1:0]          start_unit;
    logic                   start_dir;
    logic [ADDR_W-1:0]      start_addr;
    logic                   start_ack;
    logic                   start_rej;
    logic [UNITS-1:0]       busy;
    logic [UNITS-1:0]       done;
    logic                   mem_req;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [MAG_W:0]         mem_wdata;
    logic                   mem_gnt;
    logic [MAG_W:0]         mem_rdata;
    logic [UNITS-1:0]       tx_valid;
    logic [UNITS-1:0]       tx_ready;
    logic [UNITS*MAG_W-1:0] tx_data;
    logic [UNITS-1:0]       rx_valid;
    logic [UNITS-1:0]       rx_ready;
    logic [UNITS*MAG_W-1:0] rx_data;

    modport master (
        output start, start_unit, start_dir, start_addr,
        output mem_gnt, mem_rdata, tx_ready, rx_valid, rx_data,
        input  start_ack, start_rej, busy, done,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  tx_valid, tx_data, rx_ready
    );

    modport slave (
        input  start, start_unit, start_dir, start_addr,
        input  mem_gnt, mem_rdata, tx_ready, rx_valid, rx_data,
        output start_ack, start_rej, busy, done,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output tx_valid, tx_data, rx_ready
    );

endinterface

// File: rtl/io_unit.sv
// One I/O unit: moves a BLOCK-word record between memory and its device
// stream through a single holding register.
module io_unit
    import mix_io_pkg::*;
#(
    parameter int BLOCK  = 16,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int MAG_W  = DEF_MAG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              dir_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              gnt_i,
    input  logic [MAG_W-1:0]  rdata_i,
    input  logic              tx_ready_i,
    input  logic              rx_valid_i,
    input  logic [MAG_W-1:0]  rx_data_i,
    output logic              req_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [MAG_W-1:0]  data_o,
    output logic              tx_valid_o,
    output logic              rx_ready_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int CW = $clog2(BLOCK + 1);

    unit_state_e       state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CW-1:0]     cnt_q;
    logic [MAG_W-1:0]  hold_q;
    logic              busy_q;
    logic              done_q;
    logic              last;

    assign last = (cnt_q == CW'(1));

    // Record sequencing: word transfers, address/count update, busy/done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        addr_q  <= addr_i;
                        cnt_q   <= CW'(BLOCK);
                        busy_q  <= 1'b1;
                        state_q <= (dir_i == DIR_OUT) ? ST_FETCH : ST_RECV;
                    end
                end
                ST_FETCH: begin
                    if (gnt_i) begin
                        addr_q  <= addr_q + 1'b1;
                        state_q <= ST_WAITRD;
                    end
                end
                ST_WAITRD: begin
                    hold_q  <= rdata_i;
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_ready_i) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (last) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_RECV: begin
                    if (rx_valid_i) begin
                        hold_q  <= rx_data_i;
                        state_q <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    if (gnt_i) begin
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q - 1'b1;
                        if (last) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RECV;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_o      = (state_q == ST_FETCH) || (state_q == ST_STORE);
    assign we_o       = (state_q == ST_STORE);
    assign tx_valid_o = (state_q == ST_SEND);
    assign rx_ready_o = (state_q == ST_RECV);
    assign addr_o     = addr_q;
    assign data_o     = hold_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: rtl/io_channels.sv
// Multi-unit block-transfer I/O controller: start decode, round-robin
// arbitration of the units onto the shared memory port, and the mem mux.
module io_channels
    import mix_io_pkg::*;
#(
    parameter int UNITS  = 4,
    parameter int BLOCK  = 16,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int MAG_W  = DEF_MAG_W
) (
    input  logic        clk,
    input  logic        reset,
    io_channels_if.slave bus
);
    localparam int UW = unit_w(UNITS);

    logic [UNITS-1:0]             take;
    logic [UNITS-1:0]             u_req;
    logic [UNITS-1:0]             u_we;
    logic [UNITS-1:0]             u_gnt;
    logic [UNITS-1:0]             u_busy;
    logic [UNITS-1:0]             u_done;
    logic [UNITS-1:0][ADDR_W-1:0] u_addr;
    logic [UNITS-1:0][MAG_W-1:0]  u_data;

    logic [UW-1:0] rr_q;
    logic [UW-1:0] rr_d;
    logic [UW-1:0] win;
    logic [UW-1:0] cand;
    logic          found;
    logic          access;
    logic          ack_q;
    logic          rej_q;

    for (genvar u = 0; u < UNITS; u++) begin : g_unit
        // A unit still pulsing done counts as occupied for one more cycle.
        assign take[u] = bus.start
                       & (bus.start_unit == UW'(u))
                       & ~u_busy[u]
                       & ~u_done[u];
        assign u_gnt[u] = access & (win == UW'(u));

        io_unit #(
            .BLOCK (BLOCK),
            .ADDR_W(ADDR_W),
            .MAG_W (MAG_W)
        ) u_unit (
            .clk       (clk),
            .reset     (reset),
            .start_i   (take[u]),
            .dir_i     (bus.start_dir),
            .addr_i    (bus.start_addr),
            .gnt_i     (u_gnt[u]),
            .rdata_i   (bus.mem_rdata[MAG_W-1:0]),
            .tx_ready_i(bus.tx_ready[u]),
            .rx_valid_i(bus.rx_valid[u]),
            .rx_data_i (bus.rx_data[u*MAG_W +: MAG_W]),
            .req_o     (u_req[u]),
            .we_o      (u_we[u]),
            .addr_o    (u_addr[u]),
            .data_o    (u_data[u]),
            .tx_valid_o(bus.tx_valid[u]),
            .rx_ready_o(bus.rx_ready[u]),
            .busy_o    (u_busy[u]),
            .done_o    (u_done[u])
        );

        assign bus.tx_data[u*MAG_W +: MAG_W] = u_data[u];
    end

    // Pick the first requesting unit at or after the round-robin pointer.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < UNITS; i++) begin
            cand = UW'((int'(rr_q) + i) % UNITS);
            if (!found && u_req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign access = found & bus.mem_gnt;

    // Advance the pointer past the winner only when the access happens.
    always_comb begin
        rr_d = rr_q;
        if (access) begin
            rr_d = (win == UW'(UNITS - 1)) ? '0 : win + UW'(1);
        end
    end

    // Pointer state and registered start acknowledge/refuse pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q  <= '0;
            ack_q <= 1'b0;
            rej_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            ack_q <= |take;
            rej_q <= bus.start & ~(|take);
        end
    end

    assign bus.mem_req   = found;
    assign bus.mem_we    = found & u_we[win];
    assign bus.mem_addr  = found ? u_addr[win] : '0;
    assign bus.mem_wdata = (found & u_we[win]) ? {1'b0, u_data[win]} : '0;
    assign bus.start_ack = ack_q;
    assign bus.start_rej = rej_q;
    assign bus.busy      = u_busy;
    assign bus.done      = u_done;

endmodule

// File: tb/tb_io_channels.sv
// Directed bench for io_channels: OUT/IN records, address wrap, contention,
// start refusal, tx back-pressure and mid-record reset.
module tb_io_channels;
    import mix_io_pkg::*;

    localparam int UNITS = 3;
    localparam int BLOCK = 16;
    localparam int AW    = 12;
    localparam int MW    = 30;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    io_channels_if #(.UNITS(UNITS), .ADDR_W(AW), .MAG_W(MW)) bus();

    io_channels #(
        .UNITS (UNITS),
        .BLOCK (BLOCK),
        .ADDR_W(AW),
        .MAG_W (MW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [MW:0] rd_q = '0;
    logic [MW:0] wmem [4096];
    logic [MW-1:0] txl [UNITS][128];
    int txn [UNITS];
    int rxn [UNITS];
    int dn [UNITS];
    logic [AW-1:0] gl [256];
    int gl_n = 0;
    int rx_base = 0;

    assign bus.mem_rdata = rd_q;

    // Preset read image: magnitude 0x1000_0000 + address, sign = address bit 0.
    function automatic logic [MW-1:0] mag_of(input int a);
        return 30'h1000_0000 + 30'(a);
    endfunction

    // Memory model, grant log and stream/done monitors.
    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_gnt) begin
            gl[gl_n % 256] <= bus.mem_addr;
            gl_n <= gl_n + 1;
            if (bus.mem_we) wmem[bus.mem_addr] <= bus.mem_wdata;
            else rd_q <= {bus.mem_addr[0], mag_of(int'(bus.mem_addr))};
        end
        for (int u = 0; u < UNITS; u++) begin
            if (bus.tx_valid[u] && bus.tx_ready[u]) begin
                txl[u][txn[u] % 128] <= bus.tx_data[u*MW +: MW];
                txn[u] <= txn[u] + 1;
            end
            if (bus.rx_valid[u] && bus.rx_ready[u]) rxn[u] <= rxn[u] + 1;
            if (bus.done[u]) dn[u] <= dn[u] + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        bus.rx_data[2*MW +: MW] = 30'(rxn[2] - rx_base + 1);
    endtask

    task automatic req_start(input int unit, input logic dir, input int addr);
        bus.start      = 1'b1;
        bus.start_unit = 2'(unit);
        bus.start_dir  = dir;
        bus.start_addr = 12'(addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        int busy_cnt, done_at, d0, d1, b0, b1, gb, n, stable_err, req_seen;
        logic [MW-1:0] held;

        bus.start      = 1'b0;
        bus.start_unit = '0;
        bus.start_dir  = 1'b0;
        bus.start_addr = '0;
        bus.mem_gnt    = 1'b1;
        bus.tx_ready   = '1;
        bus.rx_valid   = '0;
        bus.rx_data    = '0;

        // Reset state
        tick();
        tick();
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_req", 64'(bus.mem_req), 64'(0));
        check("rst_ackrej", 64'({bus.start_ack, bus.start_rej}), 64'(0));
        check("rst_addr", 64'(bus.mem_addr), 64'(0));
        check("rst_tx", 64'({bus.tx_valid, bus.tx_data}), 64'(0));
        check("rst_rxrdy", 64'(bus.rx_ready), 64'(0));
        reset = 1'b0;

        // OUT unit 0 from address 100, no contention
        tick();
        req_start(0, DIR_OUT, 100);
        b0 = txn[0];
        busy_cnt = 0;
        done_at = 0;
        for (int c = 1; c <= 55; c++) begin
            tick();
            if (c == 1) begin
                bus.start = 1'b0;
                check("out_ack", 64'({bus.start_ack, bus.start_rej}), 64'(2));
                check("out_req1", 64'({bus.mem_req, bus.mem_we}), 64'(2));
                check("out_addr1", 64'(bus.mem_addr), 64'(100));
            end
            if (bus.busy[0]) busy_cnt++;
            if (bus.done[0]) done_at = c;
        end
        check("out_busy_cycles", 64'(busy_cnt), 64'(48));
        check("out_done_cycle", 64'(done_at), 64'(49));
        check("out_words", 64'(txn[0] - b0), 64'(16));
        for (int i = 0; i < 16; i++)
            check("out_data", 64'(txl[0][(b0 + i) % 128]),
                  64'(30'h1000_0000 + 30'(100 + i)));

        // IN unit 2 at 4090, data 1..16, wraps to address 0
        bus.rx_valid[2] = 1'b1;
        rx_base = rxn[2];
        tick();
        req_start(2, DIR_IN, 4090);
        done_at = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1) begin
                bus.start = 1'b0;
                check("in_ack", 64'(bus.start_ack), 64'(1));
            end
            if (bus.done[2]) done_at = c;
        end
        bus.rx_valid[2] = 1'b0;
        check("in_done_cycle", 64'(done_at), 64'(33));
        check("in_words", 64'(rxn[2] - rx_base), 64'(16));
        for (int k = 0; k < 16; k++)
            check("in_mem", 64'(wmem[(4090 + k) % 4096]), 64'(31'(k + 1)));

        // Units 0 and 1 OUT together, mem_gnt on odd cycles only
        d0 = dn[0];
        d1 = dn[1];
        b0 = txn[0];
        b1 = txn[1];
        gb = gl_n;
        tick();
        req_start(0, DIR_OUT, 200);
        bus.mem_gnt = 1'b0;
        tick();
        check("arb_ack0", 64'(bus.start_ack), 64'(1));
        req_start(1, DIR_OUT, 300);
        bus.mem_gnt = 1'b1;
        tick();
        bus.start = 1'b0;
        check("arb_ack1", 64'(bus.start_ack), 64'(1));
        bus.mem_gnt = 1'b0;
        n = 2;
        while (!(dn[0] == d0 + 1 && dn[1] == d1 + 1) && n < 300) begin
            tick();
            n++;
            bus.mem_gnt = n[0];
        end
        bus.mem_gnt = 1'b1;
        check("arb_both_done", 64'(n < 300), 64'(1));
        check("arb_g0", 64'(gl[gb % 256]), 64'(200));
        check("arb_g1", 64'(gl[(gb + 1) % 256]), 64'(300));
        check("arb_g2", 64'(gl[(gb + 2) % 256]), 64'(201));
        check("arb_g3", 64'(gl[(gb + 3) % 256]), 64'(301));
        check("arb_words0", 64'(txn[0] - b0), 64'(16));
        check("arb_words1", 64'(txn[1] - b1), 64'(16));
        for (int i = 0; i < 16; i++) begin
            check("arb_data0", 64'(txl[0][(b0 + i) % 128]),
                  64'(30'h1000_0000 + 30'(200 + i)));
            check("arb_data1", 64'(txl[1][(b1 + i) % 128]),
                  64'(30'h1000_0000 + 30'(300 + i)));
        end

        // Back-pressure on unit 1 plus refused starts
        d1 = dn[1];
        b1 = txn[1];
        bus.tx_ready[1] = 1'b0;
        tick();
        req_start(1, DIR_OUT, 400);
        tick();
        bus.start = 1'b0;
        check("bp_ack", 64'(bus.start_ack), 64'(1));
        n = 0;
        while (!bus.tx_valid[1] && n < 10) begin
            tick();
            n++;
        end
        check("bp_in_send", 64'(bus.tx_valid[1]), 64'(1));
        held = bus.tx_data[MW +: MW];
        check("bp_word0", 64'(held), 64'(30'h1000_0000 + 30'(400)));
        stable_err = 0;
        req_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!bus.tx_valid[1] || bus.tx_data[MW +: MW] !== held)
                stable_err++;
            if (bus.mem_req) req_seen++;
            if (k == 2) req_start(1, DIR_IN, 900);
            if (k == 3) begin
                check("rej_busy", 64'({bus.start_ack, bus.start_rej}), 64'(1));
                req_start(3, DIR_IN, 900);
            end
            if (k == 4) begin
                check("rej_range", 64'({bus.start_ack, bus.start_rej}), 64'(1));
                bus.start = 1'b0;
            end
        end
        check("bp_stable", 64'(stable_err), 64'(0));
        check("bp_no_req", 64'(req_seen), 64'(0));
        check("bp_busy", 64'(bus.busy), 64'(3'b010));
        gb = gl_n;
        bus.tx_ready[1] = 1'b1;
        n = 0;
        while (dn[1] == d1 && n < 80) begin
            tick();
            n++;
        end
        check("bp_done", 64'(dn[1] - d1), 64'(1));
        check("bp_next_addr", 64'(gl[gb % 256]), 64'(401));
        check("bp_words", 64'(txn[1] - b1), 64'(16));
        check("bp_last", 64'(txl[1][(b1 + 15) % 128]),
              64'(30'h1000_0000 + 30'(415)));

        // Reset in the middle of an IN record, during word 5
        bus.rx_valid[2] = 1'b1;
        rx_base = rxn[2];
        tick();
        req_start(2, DIR_IN, 50);
        tick();
        bus.start = 1'b0;
        for (int c = 2; c <= 10; c++) tick();
        check("mid_word5", 64'({bus.mem_req, bus.mem_we, 5'(rxn[2] - rx_base)}),
              64'({2'b11, 5'd5}));
        d1 = dn[2];
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 64'(bus.busy), 64'(0));
        check("mid_rst_req", 64'(bus.mem_req), 64'(0));
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("mid_no_done", 64'(dn[2] - d1), 64'(0));
        rx_base = rxn[2];
        tick();
        req_start(2, DIR_IN, 60);
        tick();
        bus.start = 1'b0;
        check("fresh_ack", 64'({bus.start_ack, bus.busy[2]}), 64'(3));
        n = 0;
        while (dn[2] == d1 && n < 60) begin
            tick();
            n++;
        end
        bus.rx_valid[2] = 1'b0;
        check("fresh_done", 64'(dn[2] - d1), 64'(1));
        check("fresh_first", 64'(wmem[60]), 64'(31'd1));
        check("fresh_last", 64'(wmem[75]), 64'(31'd16));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
